inst_prefetch_queue: RTL and testbench
======================================

Name: inst_prefetch_queue

Overview:
- Fetch stage directly upstream of the core's instruction decode path.
- Replaces the zero-latency instruction ROM lookup with a req/ack fetch from a multi-cycle instruction memory.
- Buffers fetched words with their PCs in a small FIFO and presents them to the core on a valid/ready interface.
- On a core redirect (taken branch, jump, jr), flushes the FIFO and restarts fetch at the new PC.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous assert, active-low (0 = reset)
redirect_valid  in  1  core requests fetch restart this cycle
redirect_pc  in  32  new fetch PC; bits [1:0] ignored and forced to 0
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  word-aligned fetch address
imem_ack  in  1  memory returns data this cycle
imem_rdata  in  32  instruction word, valid when imem_ack=1
out_valid  out  1  out_inst/out_pc hold a valid instruction
out_ready  in  1  core consumes the head entry this cycle
out_inst  out  32  head instruction (32'h0 when empty)
out_pc  out  32  PC of the head instruction
out_pc_step  out  32  out_pc + 4, mod 2^32
fill_level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset state (rst=0, asynchronous):
  - imem_req=0, imem_addr=RESET_PC, out_valid=0, out_inst=0, out_pc=0, fill_level=0.
  - FSM state = IDLE.
- FSM states:
  - IDLE: no request outstanding.
  - REQ: request outstanding; its response will be kept.
  - DRAIN: request outstanding; its response will be discarded.
- Credit rule: a new request issues only when fill_level + (outstanding ? 1 : 0) < DEPTH. At most one request is outstanding.
- IDLE -> REQ when credit is available and there is no redirect. imem_req goes high the next cycle.
- Handshake:
  - imem_req and imem_addr stay stable from assertion until the cycle imem_ack=1.
  - imem_ack is ignored when imem_req=0.
  - The ack may come in the same cycle req first rises.
- REQ with imem_ack:
  - Push {imem_rdata, imem_addr} into the FIFO.
  - fetch_pc advances by 4 (wraps 32'hFFFF_FFFC -> 0).
  - If credit remains, stay in REQ with imem_addr updated next cycle, so imem_req can stay high continuously for 1 instruction/cycle. Otherwise go to IDLE.
- Latency: ack in cycle N -> entry visible on out_valid in cycle N+1 (empty-FIFO case).
- Pop: out_valid & out_ready removes the head. Push and pop in the same cycle leave fill_level unchanged.
- Redirect (redirect_valid=1):
  - FIFO flushed at the clock edge; out_valid forced to 0 combinationally in that cycle, so no pop occurs.
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - From IDLE: go to IDLE, then a request to the new PC on the following cycle.
  - From REQ without ack: go to DRAIN, keeping imem_req and imem_addr held until ack, then discard the data.
  - From REQ with ack in the same cycle: the acked data is discarded, not pushed; go to IDLE.
  - From DRAIN: update fetch_pc only; remain in DRAIN.
- DRAIN with ack: discard the data, go to IDLE. The first request to the redirect PC is issued the next cycle.
- Back-to-back redirects: the last one wins.
- Full FIFO: no request is issued; out_ready unblocks fetch on the following cycle.
- Reset asserted mid-transaction: everything returns to reset values immediately. A late imem_ack after reset is ignored because imem_req=0.

Decomposition:
- AlicePU_const.vh gains:
  - `PFQ_ST_IDLE / `PFQ_ST_REQ / `PFQ_ST_DRAIN (2-bit state codes)
  - `IMEM_RESET_PC
  - `PFQ_DEPTH
- One sub-module, pfq_fifo: synchronous FIFO with push, pop, flush and count.
  - Holds 64-bit entries {pc, inst}.
  - When push, pop and flush occur together, flush has priority.
- FSM, credit logic and fetch_pc stay in inst_prefetch_queue.

Test Plan:
- Reset release, imem_ack tied 1, out_ready=1:
  - imem_addr sequence 0x0, 0x4, 0x8, ...
  - out_pc follows one cycle behind; out_pc_step = out_pc+4; one instruction per cycle.
- out_ready=0, imem_ack=1:
  - fill_level reaches 4, then imem_req drops.
  - Raise out_ready: 0x0, 0x4, 0x8, 0xC delivered in order, then fetch resumes at 0x10.
- Redirect to 0x0000_0103 while a request to 0x8 is pending with ack delayed 3 cycles:
  - imem_addr holds 0x8 until ack; the data is discarded.
  - Next request is 0x100; out_valid=0 until 0x100's word arrives.
- Redirect in the same cycle as an ack: acked word never appears on out_inst; next out_pc=redirect target.
- fetch_pc preset via redirect to 0xFFFF_FFF8: fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0 (wrap); out_pc_step at 0xFFFF_FFFC is 0x0.
- rst pulled low mid-request with the FIFO at 2 entries:
  - Immediately imem_req=0, out_valid=0, fill_level=0.
  - After release, first imem_addr=RESET_PC.

Source files
------------

// File: rtl/inst_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package inst_prefetch_queue_pkg;

  typedef enum logic [1:0] {
    PFQ_ST_IDLE  = 2'd0,
    PFQ_ST_REQ   = 2'd1,
    PFQ_ST_DRAIN = 2'd2
  } pfq_state_e;

  localparam int unsigned PFQ_DEPTH     = 4;
  localparam logic [31:0] IMEM_RESET_PC = 32'h0000_0000;
  localparam int unsigned PFQ_ENTRY_W   = 64;

  // Instruction fetches are always word aligned; the low two PC bits are dropped.
  function automatic logic [31:0] alignPc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/inst_prefetch_queue_fifo.sv
// Small synchronous FIFO holding {pc, inst} entries for the prefetch queue.
// Flush wins over a simultaneous push and pop.
module pfq_fifo
  import inst_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = PFQ_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [PFQ_ENTRY_W-1:0]   wdata_i,
  output logic [PFQ_ENTRY_W-1:0]   rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [PFQ_ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]          wrPtr_q;
  logic [AW-1:0]          rdPtr_q;
  logic [CW-1:0]          count_q;
  logic                   full;
  logic                   doPush;
  logic                   doPop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full || doPop);
  assign rdata_o = mem_q[rdPtr_q];
  assign count_o = count_q;

  // Entry storage; contents are only observed while count is non-zero, so no reset.
  always_ff @(posedge clk_i) begin
    if (doPush && !flush_i) begin
      mem_q[wrPtr_q] <= wdata_i;
    end
  end

  // Pointer and occupancy bookkeeping; a flush empties the queue in one edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + AW'(1);
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + AW'(1);
      end
      count_q <= count_q + CW'(doPush) - CW'(doPop);
    end
  end

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: issues req/ack fetches to a multi-cycle
// instruction memory, buffers words with their PCs and hands them to the core.
// A core redirect flushes the buffer and restarts fetch at the new PC.
module inst_prefetch_queue
  import inst_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = PFQ_DEPTH,
  parameter logic [31:0] RESET_PC = IMEM_RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_inst,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_pc_step,
  output logic [$clog2(DEPTH):0] fill_level
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  pfq_state_e             state_q;
  logic [31:0]            fetchPc_q;
  logic [31:0]            addr_q;
  logic [31:0]            redirectTarget;
  logic [31:0]            nextSeqPc;
  logic                   fifoPush;
  logic                   fifoPop;
  logic                   fifoEmpty;
  logic [PFQ_ENTRY_W-1:0] fifoHead;
  logic [CW-1:0]          fifoCount;
  logic [CW-1:0]          levelNext;
  logic                   credit;

  assign redirectTarget = alignPc(redirect_pc);
  assign nextSeqPc      = addr_q + 32'd4;

  // A request is outstanding in both REQ and DRAIN; only REQ keeps the data.
  assign imem_req  = (state_q != PFQ_ST_IDLE);
  assign imem_addr = addr_q;

  // A redirect hides the head so the core can never consume a stale word.
  assign out_valid   = !fifoEmpty && !redirect_valid;
  assign fifoPop     = out_valid && out_ready;
  assign fifoPush    = (state_q == PFQ_ST_REQ) && imem_ack && !redirect_valid;
  assign out_inst    = fifoEmpty ? 32'h0 : fifoHead[31:0];
  assign out_pc      = fifoEmpty ? 32'h0 : fifoHead[63:32];
  assign out_pc_step = out_pc + 32'd4;
  assign fill_level  = fifoCount;

  // Occupancy after this edge; a new request is allowed only if its word has room.
  assign levelNext = redirect_valid ? '0 : (fifoCount + CW'(fifoPush) - CW'(fifoPop));
  assign credit    = (levelNext < CW'(DEPTH));

  pfq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (fifoPush),
    .pop_i   (fifoPop),
    .flush_i (redirect_valid),
    .wdata_i ({addr_q, imem_rdata}),
    .rdata_o (fifoHead),
    .count_o (fifoCount),
    .empty_o (fifoEmpty)
  );

  // Fetch FSM: request issue, back-to-back streaming, and discarding in-flight data after a redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= PFQ_ST_IDLE;
      fetchPc_q <= RESET_PC;
      addr_q    <= RESET_PC;
    end else begin
      case (state_q)
        PFQ_ST_IDLE: begin
          if (redirect_valid) begin
            fetchPc_q <= redirectTarget;
          end else if (credit) begin
            state_q <= PFQ_ST_REQ;
            addr_q  <= fetchPc_q;
          end
        end
        PFQ_ST_REQ: begin
          if (redirect_valid) begin
            fetchPc_q <= redirectTarget;
            state_q   <= imem_ack ? PFQ_ST_IDLE : PFQ_ST_DRAIN;
          end else if (imem_ack) begin
            fetchPc_q <= nextSeqPc;
            if (credit) begin
              addr_q <= nextSeqPc;
            end else begin
              state_q <= PFQ_ST_IDLE;
            end
          end
        end
        PFQ_ST_DRAIN: begin
          if (redirect_valid) begin
            fetchPc_q <= redirectTarget;
          end
          if (imem_ack) begin
            state_q <= PFQ_ST_IDLE;
          end
        end
        default: begin
          state_q <= PFQ_ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed, scoreboard-based bench for inst_prefetch_queue.
module tb_inst_prefetch_queue;

   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic                   clk = 1'b0;
   logic                   rst = 1'b0;
   logic                   redirect_valid = 1'b0;
   logic [31:0]            redirect_pc = 32'h0;
   logic                   imem_req;
   logic [31:0]            imem_addr;
   logic                   imem_ack;
   logic [31:0]            imem_rdata;
   logic                   out_valid;
   logic                   out_ready = 1'b0;
   logic [31:0]            out_inst;
   logic [31:0]            out_pc;
   logic [31:0]            out_pc_step;
   logic [$clog2(DEPTH):0] fill_level;

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   logic [31:0] expAddrQ[$];
   logic [31:0] expPcQ[$];
   logic [31:0] expPc;

   int   ackMode   = 0;
   int   ackDelay  = 3;
   int   reqCnt    = 0;
   logic delayAck  = 1'b0;
   logic manualAck = 1'b0;
   bit   found;

   inst_prefetch_queue #(
      .DEPTH(DEPTH),
      .RESET_PC(RESET_PC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_inst       (out_inst),
      .out_pc         (out_pc),
      .out_pc_step    (out_pc_step),
      .fill_level     (fill_level)
   );

   always #5 clk = ~clk;

   // Memory contents are a fixed scramble of the address so each word is distinguishable
   function automatic logic [31:0] instFor(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
   endfunction

   assign imem_rdata = instFor(imem_addr);
   assign imem_ack   = (ackMode == 0) ? 1'b1 : ((ackMode == 1) ? delayAck : manualAck);

   // Delayed-ack memory: counts waiting cycles of the current request
   always @(negedge clk) begin
      reqCnt = (imem_req && !imem_ack) ? reqCnt + 1 : 0;
   end

   // Delayed-ack memory: acknowledges once the request has waited ackDelay cycles
   always @(posedge clk) begin
      #1;
      delayAck = imem_req && (reqCnt >= ackDelay);
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic redir, input logic [31:0] pc, input logic ready);
      redirect_valid = redir;
      redirect_pc    = pc;
      out_ready      = ready;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #2;
   endtask

   task automatic pushAddr(input logic [31:0] start, input int n);
      for (int i = 0; i < n; i++) expAddrQ.push_back(start + 32'(4 * i));
   endtask

   task automatic pushPc(input logic [31:0] start, input int n);
      for (int i = 0; i < n; i++) expPcQ.push_back(start + 32'(4 * i));
   endtask

   task automatic startScenario(input int mode, input logic ready);
      rst       = 1'b0;
      ackMode   = mode;
      manualAck = 1'b0;
      applyStimulus(1'b0, 32'h0, ready);
      expAddrQ.delete();
      expPcQ.delete();
      nextCycle();
      nextCycle();
   endtask

   task automatic waitDrain(input int budget, input string tag);
      int n = 0;
      while ((expAddrQ.size() != 0 || expPcQ.size() != 0) && n < budget) begin
         nextCycle();
         n++;
      end
      checkOutput(tag, 32'(expAddrQ.size() + expPcQ.size()), 32'd0);
   endtask

   // Scoreboard: every accepted fetch address and every consumed instruction is matched in order
   always @(negedge clk) begin
      if (imem_req && imem_ack && expAddrQ.size() > 0) begin
         checkOutput("imem_addr", imem_addr, expAddrQ.pop_front());
      end
      if (out_valid && out_ready && expPcQ.size() > 0) begin
         expPc = expPcQ.pop_front();
         checkOutput("out_pc", out_pc, expPc);
         checkOutput("out_inst", out_inst, instFor(expPc));
         checkOutput("out_pc_step", out_pc_step, expPc + 32'd4);
      end
   end

   initial begin
      // Reset values, then streaming with ack tied high and the core always ready
      startScenario(0, 1'b1);
      checkOutput("rst_req", 32'(imem_req), 32'd0);
      checkOutput("rst_addr", imem_addr, RESET_PC);
      checkOutput("rst_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_inst", out_inst, 32'd0);
      checkOutput("rst_pc", out_pc, 32'd0);
      checkOutput("rst_level", 32'(fill_level), 32'd0);
      pushAddr(32'h0, 8);
      pushPc(32'h0, 8);
      rst = 1'b1;
      repeat (4) nextCycle();
      for (int i = 0; i < 3; i++) begin
         checkOutput("stream_valid", 32'(out_valid), 32'd1);
         checkOutput("stream_level", 32'(fill_level), 32'd1);
         nextCycle();
      end
      waitDrain(40, "stream_drain");

      // Core stalled: queue fills to DEPTH, fetch stops, then resumes in order
      startScenario(0, 1'b0);
      pushAddr(32'h0, 5);
      pushPc(32'h0, 5);
      rst = 1'b1;
      repeat (8) nextCycle();
      checkOutput("full_level", 32'(fill_level), 32'(DEPTH));
      checkOutput("full_req", 32'(imem_req), 32'd0);
      checkOutput("full_valid", 32'(out_valid), 32'd1);
      checkOutput("full_head", out_pc, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b1);
      waitDrain(40, "full_drain");

      // Redirect while the request to 0x8 waits on a delayed ack
      startScenario(1, 1'b1);
      ackDelay = 3;
      pushAddr(32'h0, 3);
      pushAddr(32'h100, 2);
      pushPc(32'h0, 1);
      pushPc(32'h100, 2);
      rst   = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         nextCycle();
         if (imem_req && imem_addr == 32'h8 && !imem_ack) found = 1'b1;
      end
      checkOutput("drain_found", 32'(found), 32'd1);
      applyStimulus(1'b1, 32'h0000_0103, 1'b1);
      #1;
      checkOutput("redir_valid", 32'(out_valid), 32'd0);
      checkOutput("redir_level", 32'(fill_level), 32'd1);
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("drain_req", 32'(imem_req), 32'd1);
      checkOutput("drain_addr", imem_addr, 32'h8);
      checkOutput("drain_level", 32'(fill_level), 32'd0);
      waitDrain(60, "drain_drain");

      // Redirect in the same cycle as an ack: the acked word is dropped
      startScenario(2, 1'b1);
      pushAddr(32'h0, 1);
      pushAddr(32'h40, 2);
      pushPc(32'h40, 2);
      rst   = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         nextCycle();
         if (imem_req) found = 1'b1;
      end
      checkOutput("ackredir_found", 32'(found), 32'd1);
      manualAck = 1'b1;
      applyStimulus(1'b1, 32'h40, 1'b1);
      nextCycle();
      manualAck = 1'b0;
      ackMode   = 0;
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("ackredir_level", 32'(fill_level), 32'd0);
      checkOutput("ackredir_valid", 32'(out_valid), 32'd0);
      checkOutput("ackredir_req", 32'(imem_req), 32'd0);
      waitDrain(40, "ackredir_drain");

      // Fetch PC preset near the top of memory wraps to zero; low PC bits are ignored
      startScenario(2, 1'b1);
      pushAddr(32'hFFFF_FFF8, 4);
      pushPc(32'hFFFF_FFF8, 4);
      rst = 1'b1;
      applyStimulus(1'b1, 32'hFFFF_FFFB, 1'b1);
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b1);
      ackMode = 0;
      waitDrain(40, "wrap_drain");

      // Reset asserted mid-request with two entries buffered
      startScenario(0, 1'b0);
      rst   = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         nextCycle();
         if (fill_level == 2) found = 1'b1;
      end
      checkOutput("midrst_found", 32'(found), 32'd1);
      rst = 1'b0;
      #1;
      checkOutput("midrst_req", 32'(imem_req), 32'd0);
      checkOutput("midrst_valid", 32'(out_valid), 32'd0);
      checkOutput("midrst_level", 32'(fill_level), 32'd0);
      checkOutput("midrst_addr", imem_addr, RESET_PC);
      nextCycle();
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b1);
      pushAddr(RESET_PC, 2);
      pushPc(RESET_PC, 2);
      rst = 1'b1;
      waitDrain(40, "midrst_drain");

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
